// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush,
// per-register countdown scoreboard for multi-cycle ops, a structural stall
// for the single non-pipelined multi-cycle unit and a saturating stall counter.
module hazard_scoreboard_unit #(
    parameter int REG_AW = 5,
    parameter int LAT_W  = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemReadM,
    input  logic [REG_AW-1:0] Rd_M,
    input  logic [REG_AW-1:0] Rd_W,
    input  logic [REG_AW-1:0] Rs1_E,
    input  logic [REG_AW-1:0] Rs2_E,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rd_D,
    input  logic              IssueE,
    input  logic [REG_AW-1:0] IssueRdE,
    input  logic [LAT_W-1:0]  IssueLatE,
    input  logic              PCSrcE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              BubbleM,
    output logic              McBusy,
    output logic [CNT_W-1:0]  StallCount
);

    localparam int NUM_REGS = 2 ** REG_AW;

    // Forwarding select encoding for the EX operand muxes.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic [LAT_W-1:0]    busyCnt [NUM_REGS];
    logic [NUM_REGS-1:0] busyVec;
    logic [LAT_W-1:0]    unitCnt;
    logic [CNT_W-1:0]    stallCountQ;

    logic                unitBusy;
    logic                issueAccept;
    logic                loadUse;
    logic                pipelineFlush;
    logic                sbHazard;
    logic                stHazard;
    logic                stallFInt;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // One-step countdown that rests at zero.
    function automatic logic [LAT_W-1:0] countDown(input logic [LAT_W-1:0] v);
        return (v == '0) ? v : v - LAT_W'(1);
    endfunction

    // Pick the newest in-flight producer of a source register (MEM beats WB).
    function automatic logic [1:0] fwdSel(
        input logic [REG_AW-1:0] rs,
        input logic              wrM,
        input logic [REG_AW-1:0] rdM,
        input logic              wrW,
        input logic [REG_AW-1:0] rdW
    );
        if (wrM && (rdM != '0) && (rdM == rs)) begin
            return FWD_MEM;
        end
        if (wrW && (rdW != '0) && (rdW == rs)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

    // An ID operand is pending if its register is still counting down, or is
    // the target of a multi-cycle op being issued right now (same-cycle bypass).
    function automatic logic srcPending(
        input logic [REG_AW-1:0]   r,
        input logic [NUM_REGS-1:0] busy,
        input logic                issue,
        input logic [REG_AW-1:0]   issueRd
    );
        return (r != '0) && (busy[r] || (issue && (r == issueRd)));
    endfunction

    assign unitBusy    = (unitCnt != '0);
    assign issueAccept = IssueE && !unitBusy;

    // Flatten the scoreboard counters into a busy bit per register; r0 never busy.
    always_comb begin
        busyVec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busyVec[r] = (busyCnt[r] != '0);
        end
    end

    // Per-register countdown: an accepted issue reloads its entry, others tick down.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                busyCnt[r] <= '0;
            end
        end else begin
            busyCnt[0] <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (issueAccept && (IssueRdE == REG_AW'(r))) begin
                    busyCnt[r] <= IssueLatE;
                end else begin
                    busyCnt[r] <= countDown(busyCnt[r]);
                end
            end
        end
    end

    // Occupancy of the non-pipelined multi-cycle unit; issues while busy are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            unitCnt <= '0;
        end else if (issueAccept) begin
            unitCnt <= IssueLatE;
        end else begin
            unitCnt <= countDown(unitCnt);
        end
    end

    // Hazard detection and stall/flush priority: load-use, then flush, then SB/ST.
    always_comb begin
        loadUse       = MemReadM && (Rd_M != '0) &&
                        ((Rd_M == Rs1_E) || (Rd_M == Rs2_E));
        pipelineFlush = PCSrcE && !loadUse;
        sbHazard      = srcPending(Rs1_D, busyVec, IssueE, IssueRdE) ||
                        srcPending(Rs2_D, busyVec, IssueE, IssueRdE) ||
                        srcPending(Rd_D,  busyVec, IssueE, IssueRdE);
        stHazard      = unitBusy && IssueE;

        ForwardAE  = FWD_REG;
        ForwardBE  = FWD_REG;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        BubbleM    = 1'b0;
        McBusy     = 1'b0;
        StallCount = '0;

        if (rst) begin
            ForwardAE  = fwdSel(Rs1_E, RegWriteM, Rd_M, RegWriteW, Rd_W);
            ForwardBE  = fwdSel(Rs2_E, RegWriteM, Rd_M, RegWriteW, Rd_W);
            McBusy     = unitBusy;
            StallCount = stallCountQ;
            if (loadUse) begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallE  = 1'b1;
                BubbleM = 1'b1;
            end else if (pipelineFlush) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (sbHazard || stHazard) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
        stallFInt = StallF;
    end

    // Stall performance counter: one count per cycle with StallF high, saturating.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stallCountQ <= '0;
        end else if (stallFInt) begin
            stallCountQ <= satInc(stallCountQ);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed scenarios plus random traffic,
// checked against a timestamp-based model of register/unit availability.
module tb_hazard_scoreboard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       RegWriteM, RegWriteW, MemReadM;
    logic [4:0] Rd_M, Rd_W, Rs1_E, Rs2_E, Rs1_D, Rs2_D, Rd_D;
    logic       IssueE;
    logic [4:0] IssueRdE;
    logic [3:0] IssueLatE;
    logic       PCSrcE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, BubbleM, McBusy;
    logic [3:0] StallCount;

    int nChecks = 0;
    int nFail   = 0;

    // Model state: each register / the unit is busy through the stored cycle number.
    longint cyc = 0;
    longint busyUntil [32];
    longint unitUntil = -1;
    int     stallCnt  = 0;

    logic [1:0] eFA, eFB;
    logic       eSF, eSD, eSE, eFD, eFE, eBM, eMB;
    logic [3:0] eSC;

    hazard_scoreboard_unit #(.REG_AW(5), .LAT_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReadM(MemReadM),
        .Rd_M(Rd_M), .Rd_W(Rd_W), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
        .IssueE(IssueE), .IssueRdE(IssueRdE), .IssueLatE(IssueLatE),
        .PCSrcE(PCSrcE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .BubbleM(BubbleM),
        .McBusy(McBusy), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (RegWriteM && Rd_M != 0 && Rd_M == rs) return 2'b10;
        if (RegWriteW && Rd_W != 0 && Rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit pend(input logic [4:0] r);
        return (r != 0) && ((cyc <= busyUntil[r]) || (IssueE && r == IssueRdE));
    endfunction

    task automatic clearInputs();
        rst = 1'b1; RegWriteM = 0; RegWriteW = 0; MemReadM = 0;
        Rd_M = 0; Rd_W = 0; Rs1_E = 0; Rs2_E = 0; Rs1_D = 0; Rs2_D = 0; Rd_D = 0;
        IssueE = 0; IssueRdE = 0; IssueLatE = 0; PCSrcE = 0;
    endtask

    // Mid-cycle: derive expected outputs from the hazard rules and compare.
    task automatic settle();
        bit lu, fl, sb, st, mb;
        @(negedge clk);
        mb = (cyc <= unitUntil);
        lu = MemReadM && Rd_M != 0 && (Rd_M == Rs1_E || Rd_M == Rs2_E);
        fl = PCSrcE && !lu;
        sb = pend(Rs1_D) || pend(Rs2_D) || pend(Rd_D);
        st = mb && IssueE;
        eFA = 0; eFB = 0; eSF = 0; eSD = 0; eSE = 0; eFD = 0; eFE = 0; eBM = 0;
        eMB = 0; eSC = 0;
        if (rst) begin
            eFA = fwd(Rs1_E);
            eFB = fwd(Rs2_E);
            eMB = mb;
            eSC = 4'(stallCnt);
            if (lu) begin
                eSF = 1; eSD = 1; eSE = 1; eBM = 1;
            end else if (fl) begin
                eFD = 1; eFE = 1;
            end else if (sb || st) begin
                eSF = 1; eSD = 1; eFE = 1;
            end
        end
        chk("ForwardAE",  32'(ForwardAE),  32'(eFA));
        chk("ForwardBE",  32'(ForwardBE),  32'(eFB));
        chk("StallF",     32'(StallF),     32'(eSF));
        chk("StallD",     32'(StallD),     32'(eSD));
        chk("StallE",     32'(StallE),     32'(eSE));
        chk("FlushD",     32'(FlushD),     32'(eFD));
        chk("FlushE",     32'(FlushE),     32'(eFE));
        chk("BubbleM",    32'(BubbleM),    32'(eBM));
        chk("McBusy",     32'(McBusy),     32'(eMB));
        chk("StallCount", 32'(StallCount), 32'(eSC));
    endtask

    // Clock edge: advance the availability model with the inputs held this cycle.
    task automatic advance();
        @(posedge clk);
        if (!rst) begin
            foreach (busyUntil[i]) busyUntil[i] = cyc;
            unitUntil = cyc;
            stallCnt  = 0;
        end else begin
            if (eSF && stallCnt < 15) stallCnt++;
            if (IssueE && !(cyc <= unitUntil)) begin
                unitUntil = cyc + longint'(IssueLatE);
                if (IssueRdE != 0) busyUntil[IssueRdE] = cyc + longint'(IssueLatE);
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        foreach (busyUntil[i]) busyUntil[i] = -1;
        clearInputs();

        // Reset: every output forced low.
        rst = 0;
        settle();
        chk("rst_StallF", 32'(StallF), 32'd0);
        advance();
        settle(); advance();
        rst = 1;

        // Forwarding priority.
        Rd_M = 5; Rd_W = 5; Rs1_E = 5; RegWriteM = 1; RegWriteW = 1;
        settle(); chk("t1_memWins", 32'(ForwardAE), 32'd2); advance();
        RegWriteM = 0;
        settle(); chk("t1_wbOnly", 32'(ForwardAE), 32'd1); advance();
        RegWriteM = 1; Rd_M = 0; Rd_W = 0; Rs1_E = 0;
        settle(); chk("t1_rdZero", 32'(ForwardAE), 32'd0); advance();
        clearInputs();

        // Load-use stall, branch in the same cycle is ignored.
        MemReadM = 1; Rd_M = 7; Rs2_E = 7; PCSrcE = 1;
        settle();
        chk("t2_StallE", 32'(StallE), 32'd1);
        chk("t2_BubbleM", 32'(BubbleM), 32'd1);
        chk("t2_FlushD", 32'(FlushD), 32'd0);
        advance();
        clearInputs();

        // Scoreboard countdown on r9, latency 3.
        IssueE = 1; IssueRdE = 9; IssueLatE = 3; Rs1_D = 9;
        settle(); chk("t3_bypass", 32'(StallD), 32'd1); chk("t3_bypassFE", 32'(FlushE), 32'd1);
        advance();
        IssueE = 0;
        for (int k = 1; k <= 3; k++) begin
            settle(); chk("t3_busy", 32'(StallD), 32'd1); advance();
        end
        settle(); chk("t3_release", 32'(StallD), 32'd0); chk("t3_unitIdle", 32'(McBusy), 32'd0);
        advance();
        clearInputs();

        // Structural stall: second issue while the unit is busy is dropped.
        IssueE = 1; IssueRdE = 10; IssueLatE = 5;
        settle(); advance();
        IssueRdE = 11; IssueLatE = 2;
        settle(); chk("t4_StallF", 32'(StallF), 32'd1); chk("t4_McBusy", 32'(McBusy), 32'd1);
        advance();
        IssueE = 0; Rs1_D = 11;
        settle(); chk("t4_r11free", 32'(StallD), 32'd0); chk("t4_busy2", 32'(McBusy), 32'd1);
        advance();
        Rs1_D = 0;
        for (int k = 0; k < 3; k++) begin
            settle(); chk("t4_busyN", 32'(McBusy), 32'd1); advance();
        end
        settle(); chk("t4_unitDone", 32'(McBusy), 32'd0); advance();
        clearInputs();

        // Flush beats the scoreboard; reset mid-countdown clears it.
        IssueE = 1; IssueRdE = 4; IssueLatE = 6;
        settle(); advance();
        IssueE = 0; Rs1_D = 4; PCSrcE = 1;
        settle();
        chk("t5_FlushD", 32'(FlushD), 32'd1);
        chk("t5_FlushE", 32'(FlushE), 32'd1);
        chk("t5_StallD", 32'(StallD), 32'd0);
        advance();
        PCSrcE = 0;
        settle(); chk("t5_stillBusy", 32'(StallD), 32'd1); advance();
        rst = 0;
        settle(); chk("t5_rstForced", 32'(StallD), 32'd0); advance();
        rst = 1;
        settle();
        chk("t5_cleared", 32'(StallD), 32'd0);
        chk("t5_cntZero", 32'(StallCount), 32'd0);
        advance();
        clearInputs();

        // Saturation of the 4-bit stall counter.
        MemReadM = 1; Rd_M = 3; Rs1_E = 3;
        for (int k = 0; k < 20; k++) begin
            settle(); advance();
        end
        settle(); chk("t6_saturated", 32'(StallCount), 32'hF); advance();
        clearInputs();
        rst = 0; settle(); advance(); rst = 1;

        // Random traffic over a small register window to provoke collisions.
        for (int k = 0; k < 400; k++) begin
            rst       = ($urandom_range(0, 59) != 0);
            RegWriteM = 1'($urandom);
            RegWriteW = 1'($urandom);
            MemReadM  = ($urandom_range(0, 3) == 0);
            Rd_M      = 5'($urandom_range(0, 7));
            Rd_W      = 5'($urandom_range(0, 7));
            Rs1_E     = 5'($urandom_range(0, 7));
            Rs2_E     = 5'($urandom_range(0, 7));
            Rs1_D     = 5'($urandom_range(0, 7));
            Rs2_D     = 5'($urandom_range(0, 7));
            Rd_D      = 5'($urandom_range(0, 7));
            IssueE    = ($urandom_range(0, 3) == 0);
            IssueRdE  = 5'($urandom_range(0, 7));
            IssueLatE = 4'($urandom_range(1, 15));
            PCSrcE    = ($urandom_range(0, 7) == 0);
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
